hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage RV32I pipeline: fetch → ID → EX → MEM → WB.
- Drives the PC write enable and the pass/clear controls for the S1–S4 pipeline registers.
- Produces the EX-stage forwarding selects for rs1/rs2.
- Sequences load-use stalls and taken-branch/jump flushes with a small FSM. Purely control: no datapath storage besides FSM, counters and optional perf counters.

Parameters:
- LU_STALL_CYC, 1, bubble cycles inserted per load-use hazard (1..3; the LSU read latency).
- XLEN_IDX, 5, register-index width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_s1_rs1, i_s1_rs2  in  5 each  source indices of instruction in S1 register (ID stage).
- i_s1_use_rs1, i_s1_use_rs2  in  1 each  ID instruction actually reads the source.
- i_s2_rs1, i_s2_rs2  in  5 each  source indices of instruction in S2 register (EX stage).
- i_s2_rd  in  5  destination of EX instruction.
- i_s2_wren  in  1  EX instruction writes rd.
- i_s2_is_load  in  1  EX instruction is a load.
- i_s3_rd, i_s3_wren  in  5, 1  destination/write enable of MEM instruction.
- i_s3_pc_sel  in  1  taken branch/jump resolved in MEM (PC mux select).
- i_s4_rd, i_s4_wren  in  5, 1  destination/write enable of WB instruction.
- o_pc_en  out  1  PC register write enable.
- o_pass_s1..o_pass_s4  out  1 each  pipeline-register write enables.
- o_clr_fet, o_clr_id, o_clr_ex, o_clr_mem  out  1 each  pipeline-register clear (bubble insert), sampled on next edge.
- o_fwd_a, o_fwd_b  out  2 each  00 = register value, 01 = S3 ALU result, 10 = WB data, 11 reserved.
- o_stall_cnt, o_flush_cnt  out  32 each  perf counters (see Optional Feature).

Behaviour:
- Reset (i_reset==0 at edge): state=RUN, counter=0, perf counters=0.
- While reset is low, outputs are forced: o_pc_en=0, all o_pass=0, all o_clr=1, o_fwd=00.
- States: RUN, STALL, FLUSH.
- Load-use hazard (LU): i_s2_is_load & i_s2_wren & i_s2_rd≠0 & ((i_s1_use_rs1 & i_s1_rs1==i_s2_rd) | (i_s1_use_rs2 & i_s1_rs2==i_s2_rd)).
- RUN:
  - Defaults: o_pc_en=1, all o_pass=1, all o_clr=0.
  - If i_s3_pc_sel: o_clr_fet=o_clr_id=o_clr_ex=1 (same cycle, so the three younger instructions are squashed at the edge while PC loads the target); next=FLUSH.
  - Else if LU: o_pc_en=0, o_pass_s1=0, o_clr_id=1 (bubble into S2); counter←LU_STALL_CYC−1; next = (LU_STALL_CYC==1) ? RUN : STALL.
- STALL:
  - Hold PC and S1 as above; o_clr_id=1; counter decrements; exit to RUN when counter==0.
  - i_s3_pc_sel during STALL wins: apply flush, go to FLUSH, discard counter.
- FLUSH:
  - One cycle; all pass=1, no clears.
  - i_s3_pc_sel and LU detection are masked, because S1–S3 hold bubbles.
  - Next=RUN.
- Priority: reset > redirect > load-use > run.
- Forwarding (combinational, every state), per source rsX in {i_s2_rs1, i_s2_rs2}:
  - 01 if i_s3_wren & i_s3_rd≠0 & i_s3_rd==rsX.
  - Else 10 if i_s4_wren & i_s4_rd≠0 & i_s4_rd==rsX.
  - Else 00.
  - S3 beats S4 (youngest producer).
  - A load in S3 never matches a consumer in S2, because LU guarantees the bubble; a match here is an assertion failure.
- x0 never forwards and never causes a stall.
- o_pass_s4 and o_clr_mem are always 1/0 outside reset; MEM→WB is never stalled.

Optional Feature:
- HAZARD_PERF_EN defined:
  - o_stall_cnt increments once per cycle with o_pc_en==0 outside reset.
  - o_flush_cnt increments once per redirect accepted.
  - Both wrap at 2^32 and clear on reset.
- Undefined: both outputs tied to 0, no flops inferred.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_FLUSH} hz_state_e.
  - typedef enum logic [1:0] {FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10} fwd_sel_e.
  - Constant REG_X0 = 5'd0.
- One sub-module: fwd_sel, a combinational comparator instantiated twice (rs1, rs2), inputs rs/s3/s4 fields, output fwd_sel_e.

Test Plan:
1. Reset held low 3 cycles then released → o_pc_en=0 and all o_clr=1 during reset; first cycle after release o_pc_en=1, pass=1111, clr=0000, o_fwd_a/b=00.
2. S3 rd=5 wren, S4 rd=5 wren, S2 rs1=5, rs2=6 → o_fwd_a=01, o_fwd_b=00; set S3 wren=0 → o_fwd_a=10; rd=0 on both → 00.
3. LU_STALL_CYC=1, S2 load rd=7, S1 rs2=7 use_rs2=1 → exactly one cycle o_pc_en=0, o_pass_s1=0, o_clr_id=1; following cycle RUN defaults; o_stall_cnt=1 with HAZARD_PERF_EN.
4. LU_STALL_CYC=3, same hazard → o_pc_en low for 3 consecutive cycles; assert i_s3_pc_sel in 2nd cycle → clr_fet/id/ex=1 that cycle, then FLUSH, then RUN.
5. i_s3_pc_sel=1 with simultaneous LU → flush wins (o_pc_en=1, clr_fet/id/ex=1); next cycle i_s3_pc_sel=1 again → ignored (FLUSH masks); o_flush_cnt=1.
6. Reset asserted during STALL → next cycle state RUN after release, counter cleared, no residual stall.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding selects
// and the hard-wired zero register index.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_FLUSH} hz_state_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// EX-stage bypass selector for one source operand.
// The MEM-stage producer is younger than the WB one, so it takes priority.
module fwd_sel
  import pipe_ctrl_pkg::*;
#(
  parameter int IDX_W = 5
) (
  input  logic [IDX_W-1:0] i_rs,
  input  logic [IDX_W-1:0] i_s3_rd,
  input  logic             i_s3_wren,
  input  logic [IDX_W-1:0] i_s4_rd,
  input  logic             i_s4_wren,
  output fwd_sel_e         o_sel
);

  logic s3_hit, s4_hit;

  // x0 is never a real producer, so it never forwards
  assign s3_hit = i_s3_wren & (i_s3_rd != IDX_W'(REG_X0)) & (i_s3_rd == i_rs);
  assign s4_hit = i_s4_wren & (i_s4_rd != IDX_W'(REG_X0)) & (i_s4_rd == i_rs);

  always_comb begin
    o_sel = FWD_REG;
    if (s3_hit)      o_sel = FWD_MEM;
    else if (s4_hit) o_sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stalls, redirect
// flushes and EX forwarding selects. Define HAZARD_PERF_EN to enable perf counters.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LU_STALL_CYC = 1,
  parameter int XLEN_IDX     = 5
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [XLEN_IDX-1:0] i_s1_rs1,
  input  logic [XLEN_IDX-1:0] i_s1_rs2,
  input  logic                i_s1_use_rs1,
  input  logic                i_s1_use_rs2,
  input  logic [XLEN_IDX-1:0] i_s2_rs1,
  input  logic [XLEN_IDX-1:0] i_s2_rs2,
  input  logic [XLEN_IDX-1:0] i_s2_rd,
  input  logic                i_s2_wren,
  input  logic                i_s2_is_load,
  input  logic [XLEN_IDX-1:0] i_s3_rd,
  input  logic                i_s3_wren,
  input  logic                i_s3_pc_sel,
  input  logic [XLEN_IDX-1:0] i_s4_rd,
  input  logic                i_s4_wren,
  output logic                o_pc_en,
  output logic                o_pass_s1,
  output logic                o_pass_s2,
  output logic                o_pass_s3,
  output logic                o_pass_s4,
  output logic                o_clr_fet,
  output logic                o_clr_id,
  output logic                o_clr_ex,
  output logic                o_clr_mem,
  output logic [1:0]          o_fwd_a,
  output logic [1:0]          o_fwd_b,
  output logic [31:0]         o_stall_cnt,
  output logic [31:0]         o_flush_cnt
);

  localparam int CNT_W = 2;

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu_hit;
  logic             pc_en, pass_s1, clr_fet, clr_id, clr_ex;
  fwd_sel_e         fwd_a, fwd_b;

  assign lu_hit = i_s2_is_load & i_s2_wren & (i_s2_rd != XLEN_IDX'(REG_X0)) &
                  ((i_s1_use_rs1 & (i_s1_rs1 == i_s2_rd)) |
                   (i_s1_use_rs2 & (i_s1_rs2 == i_s2_rd)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_en   = 1'b1;
    pass_s1 = 1'b1;
    clr_fet = 1'b0;
    clr_id  = 1'b0;
    clr_ex  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (i_s3_pc_sel) begin
          {clr_fet, clr_id, clr_ex} = 3'b111;
          state_d = ST_FLUSH;
        end else if (lu_hit) begin
          pc_en   = 1'b0;
          pass_s1 = 1'b0;
          clr_id  = 1'b1;
          cnt_d   = CNT_W'(LU_STALL_CYC - 1);
          state_d = (LU_STALL_CYC == 1) ? ST_RUN : ST_STALL;
        end
      end
      ST_STALL: begin
        if (i_s3_pc_sel) begin
          {clr_fet, clr_id, clr_ex} = 3'b111;
          cnt_d   = '0;
          state_d = ST_FLUSH;
        end else begin
          pc_en   = 1'b0;
          pass_s1 = 1'b0;
          clr_id  = 1'b1;
          cnt_d   = cnt_q - 1'b1;
          state_d = (cnt_d == '0) ? ST_RUN : ST_STALL;
        end
      end
      // S1-S3 hold bubbles here, so redirect and load-use inputs are stale
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    if (!i_reset) begin
      state_d = ST_RUN;
      cnt_d   = '0;
      pc_en   = 1'b0;
      pass_s1 = 1'b0;
      {clr_fet, clr_id, clr_ex} = 3'b111;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  fwd_sel #(.IDX_W(XLEN_IDX)) u_fwd_a (
    .i_rs      (i_s2_rs1),
    .i_s3_rd   (i_s3_rd),
    .i_s3_wren (i_s3_wren),
    .i_s4_rd   (i_s4_rd),
    .i_s4_wren (i_s4_wren),
    .o_sel     (fwd_a)
  );

  fwd_sel #(.IDX_W(XLEN_IDX)) u_fwd_b (
    .i_rs      (i_s2_rs2),
    .i_s3_rd   (i_s3_rd),
    .i_s3_wren (i_s3_wren),
    .i_s4_rd   (i_s4_rd),
    .i_s4_wren (i_s4_wren),
    .o_sel     (fwd_b)
  );

  // MEM->WB never stalls, so the back half only reacts to reset
  assign o_pc_en   = pc_en;
  assign o_pass_s1 = pass_s1;
  assign o_pass_s2 = i_reset;
  assign o_pass_s3 = i_reset;
  assign o_pass_s4 = i_reset;
  assign o_clr_fet = clr_fet;
  assign o_clr_id  = clr_id;
  assign o_clr_ex  = clr_ex;
  assign o_clr_mem = ~i_reset;
  assign o_fwd_a   = i_reset ? fwd_a : FWD_REG;
  assign o_fwd_b   = i_reset ? fwd_b : FWD_REG;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        redirect;

  assign redirect = i_reset & i_s3_pc_sel & (state_q != ST_FLUSH);

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, ~pc_en};
    flush_cnt_d = flush_cnt_q + {31'd0, redirect};
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`else
  assign o_stall_cnt = 32'd0;
  assign o_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench: two controllers (1- and 3-cycle load-use stall) share stimulus;
// a behavioural model queues expected outputs, a negedge monitor compares them.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic [4:0] s1_rs1, s1_rs2;
    logic       u1, u2;
    logic [4:0] s2_rs1, s2_rs2, s2_rd;
    logic       s2_wren, s2_ld;
    logic [4:0] s3_rd;
    logic       s3_wren, pc_sel;
    logic [4:0] s4_rd;
    logic       s4_wren;
  } stim_t;

  typedef struct packed {
    logic [12:0] ctl;
    logic [31:0] sc, fc;
  } exp_t;

  typedef struct packed {
    exp_t e1;
    exp_t e0;
  } exp_pair_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       i_reset = 1'b0;
  logic [4:0] s1_rs1 = '0, s1_rs2 = '0, s2_rs1 = '0, s2_rs2 = '0, s2_rd = '0, s3_rd = '0, s4_rd = '0;
  logic       u1 = 0, u2 = 0, s2_wren = 0, s2_ld = 0, s3_wren = 0, pc_sel = 0, s4_wren = 0;

  logic        pc_en[2], p1[2], p2[2], p3[2], p4[2], cf[2], ci[2], ce[2], cm[2];
  logic [1:0]  fa[2], fb[2];
  logic [31:0] sc[2], fc[2];

  hazard_ctrl #(.LU_STALL_CYC(1)) u_dut0 (
    .i_clk(clk), .i_reset(i_reset),
    .i_s1_rs1(s1_rs1), .i_s1_rs2(s1_rs2), .i_s1_use_rs1(u1), .i_s1_use_rs2(u2),
    .i_s2_rs1(s2_rs1), .i_s2_rs2(s2_rs2), .i_s2_rd(s2_rd), .i_s2_wren(s2_wren),
    .i_s2_is_load(s2_ld), .i_s3_rd(s3_rd), .i_s3_wren(s3_wren), .i_s3_pc_sel(pc_sel),
    .i_s4_rd(s4_rd), .i_s4_wren(s4_wren),
    .o_pc_en(pc_en[0]), .o_pass_s1(p1[0]), .o_pass_s2(p2[0]), .o_pass_s3(p3[0]),
    .o_pass_s4(p4[0]), .o_clr_fet(cf[0]), .o_clr_id(ci[0]), .o_clr_ex(ce[0]),
    .o_clr_mem(cm[0]), .o_fwd_a(fa[0]), .o_fwd_b(fb[0]),
    .o_stall_cnt(sc[0]), .o_flush_cnt(fc[0])
  );

  hazard_ctrl #(.LU_STALL_CYC(3)) u_dut1 (
    .i_clk(clk), .i_reset(i_reset),
    .i_s1_rs1(s1_rs1), .i_s1_rs2(s1_rs2), .i_s1_use_rs1(u1), .i_s1_use_rs2(u2),
    .i_s2_rs1(s2_rs1), .i_s2_rs2(s2_rs2), .i_s2_rd(s2_rd), .i_s2_wren(s2_wren),
    .i_s2_is_load(s2_ld), .i_s3_rd(s3_rd), .i_s3_wren(s3_wren), .i_s3_pc_sel(pc_sel),
    .i_s4_rd(s4_rd), .i_s4_wren(s4_wren),
    .o_pc_en(pc_en[1]), .o_pass_s1(p1[1]), .o_pass_s2(p2[1]), .o_pass_s3(p3[1]),
    .o_pass_s4(p4[1]), .o_clr_fet(cf[1]), .o_clr_id(ci[1]), .o_clr_ex(ce[1]),
    .o_clr_mem(cm[1]), .o_fwd_a(fa[1]), .o_fwd_b(fb[1]),
    .o_stall_cnt(sc[1]), .o_flush_cnt(fc[1])
  );

  int n_checks = 0;
  int n_errors = 0;
  exp_pair_t exp_q[$];

  // Reference state: mode 0=normal, 1=stalling, 2=just redirected; left=stall cycles still owed
  int          m_mode[2];
  int          m_left[2];
  logic [31:0] m_sc[2], m_fc[2];
  int          lu_lim[2];

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs, input stim_t s);
    if (s.s3_wren && s.s3_rd != 0 && s.s3_rd == rs) return 2'b01;
    if (s.s4_wren && s.s4_rd != 0 && s.s4_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_step(input int d, input stim_t s, output exp_t e);
    logic       hz, pce;
    logic [3:0] pass, clr;
    logic [1:0] a, b;
    hz = s.s2_ld && s.s2_wren && s.s2_rd != 0 &&
         ((s.u1 && s.s1_rs1 == s.s2_rd) || (s.u2 && s.s1_rs2 == s.s2_rd));
    pce = 1'b1; pass = 4'b1111; clr = 4'b0000;
    a = fwd_ref(s.s2_rs1, s); b = fwd_ref(s.s2_rs2, s);
`ifdef HAZARD_PERF_EN
    e.sc = m_sc[d]; e.fc = m_fc[d];
`else
    e.sc = 32'd0; e.fc = 32'd0;
`endif
    if (!s.rst) begin
      pce = 1'b0; pass = 4'b0000; clr = 4'b1111; a = 2'b00; b = 2'b00;
      m_mode[d] = 0; m_left[d] = 0; m_sc[d] = 0; m_fc[d] = 0;
    end else if (m_mode[d] == 2) begin
      m_mode[d] = 0;
    end else if (s.pc_sel) begin
      clr = 4'b1110;
      m_fc[d] = m_fc[d] + 1;
      m_mode[d] = 2; m_left[d] = 0;
    end else if (m_mode[d] == 1 || hz) begin
      pce = 1'b0; pass = 4'b0111; clr = 4'b0100;
      m_sc[d] = m_sc[d] + 1;
      if (m_mode[d] == 0) m_left[d] = lu_lim[d] - 1;
      else                m_left[d] = m_left[d] - 1;
      m_mode[d] = (m_left[d] > 0) ? 1 : 0;
    end
    e.ctl = {pce, pass, clr, a, b};
  endtask

  task automatic step(input stim_t s);
    exp_pair_t p;
    exp_t      e;
    @(posedge clk);
    #1;
    i_reset = s.rst; s1_rs1 = s.s1_rs1; s1_rs2 = s.s1_rs2; u1 = s.u1; u2 = s.u2;
    s2_rs1 = s.s2_rs1; s2_rs2 = s.s2_rs2; s2_rd = s.s2_rd; s2_wren = s.s2_wren;
    s2_ld = s.s2_ld; s3_rd = s.s3_rd; s3_wren = s.s3_wren; pc_sel = s.pc_sel;
    s4_rd = s.s4_rd; s4_wren = s.s4_wren;
    model_step(0, s, e); p.e0 = e;
    model_step(1, s, e); p.e1 = e;
    exp_q.push_back(p);
  endtask

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, d, $time, act, exp);
    end
  endtask

  initial begin
    exp_pair_t p;
    exp_t      e;
    logic [12:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        p = exp_q.pop_front();
        for (int d = 0; d < 2; d++) begin
          e = (d == 0) ? p.e0 : p.e1;
          act = {pc_en[d], p1[d], p2[d], p3[d], p4[d], cf[d], ci[d], ce[d], cm[d], fa[d], fb[d]};
          chk("ctl", d, {19'd0, act}, {19'd0, e.ctl});
          chk("stall_cnt", d, sc[d], e.sc);
          chk("flush_cnt", d, fc[d], e.fc);
        end
      end
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  function automatic stim_t lu_stim();
    stim_t s;
    s = idle();
    s.s2_ld = 1'b1; s.s2_wren = 1'b1; s.s2_rd = 5'd7;
    s.s1_rs2 = 5'd7; s.u2 = 1'b1;
    return s;
  endfunction

  initial begin
    stim_t s;
    lu_lim[0] = 1; lu_lim[1] = 3;
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = 0; m_left[d] = 0; m_sc[d] = 0; m_fc[d] = 0;
    end
    // reset held for three cycles, then defaults
    s = idle(); s.rst = 1'b0;
    repeat (3) step(s);
    step(idle());
    // forwarding priority and x0
    s = idle(); s.s3_rd = 5; s.s3_wren = 1; s.s4_rd = 5; s.s4_wren = 1;
    s.s2_rs1 = 5; s.s2_rs2 = 6;
    step(s);
    s.s3_wren = 0; step(s);
    s.s3_wren = 1; s.s3_rd = 0; s.s4_rd = 0; s.s2_rs1 = 0; step(s);
    // load-use, then idle while stalls drain
    step(lu_stim());
    repeat (4) step(idle());
    // redirect in the second stall cycle, then a masked redirect
    step(lu_stim());
    s = idle(); s.pc_sel = 1; step(s); step(s);
    repeat (2) step(idle());
    // redirect concurrent with load-use wins
    s = lu_stim(); s.pc_sel = 1; step(s);
    s = idle(); s.pc_sel = 1; step(s);
    step(idle());
    // reset while stalling
    step(lu_stim());
    s = idle(); s.rst = 1'b0; step(s);
    repeat (4) step(idle());
    // randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      s.rst     = ($urandom_range(0, 59) != 0);
      s.s1_rs1  = 5'($urandom_range(0, 7));
      s.s1_rs2  = 5'($urandom_range(0, 7));
      s.u1      = 1'($urandom);
      s.u2      = 1'($urandom);
      s.s2_rs1  = 5'($urandom_range(0, 7));
      s.s2_rs2  = 5'($urandom_range(0, 7));
      s.s2_rd   = 5'($urandom_range(0, 7));
      s.s2_wren = 1'($urandom);
      s.s2_ld   = ($urandom_range(0, 2) == 0);
      s.s3_rd   = 5'($urandom_range(0, 7));
      s.s3_wren = 1'($urandom);
      s.pc_sel  = ($urandom_range(0, 9) == 0);
      s.s4_rd   = 5'($urandom_range(0, 7));
      s.s4_wren = 1'($urandom);
      step(s);
    end
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expected entries never compared", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
